// File: rtl/st_bus_arbiter.sv
// Bus arbiter sharing the 68000 CPU bus with NREQ DMA-style masters via br_n/bg_n/bgack_n.
// Define ST_ARB_ROUND_ROBIN_EN for round-robin selection instead of fixed priority.
module st_bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_HOLD = 0,
    parameter int CW       = 8,
    localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            phi1,
    input  logic            phi2,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            br_n,
    input  logic            bg_n,
    output logic            bgack_n,
    input  logic            as_n,
    output logic            owner_valid,
    output logic [OW-1:0]   owner
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        OWN,
        REL
    } stateT;

    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    stateT            r_state;
    logic [NREQ-1:0]  r_gnt;
    logic             r_brN;
    logic             r_bgackN;
    logic             r_ownerValid;
    logic [OW-1:0]    r_owner;
    logic [OW-1:0]    r_sel;
    logic [CW-1:0]    r_holdCnt;

    stateT            w_stateNext;
    logic [NREQ-1:0]  w_gntNext;
    logic             w_brNNext;
    logic             w_bgackNNext;
    logic             w_ownerValidNext;
    logic [OW-1:0]    w_ownerNext;
    logic [OW-1:0]    w_selNext;
    logic [CW-1:0]    w_holdNext;
    logic [OW-1:0]    w_pick;
    logic             w_holdExpired;
    logic             w_unused;

`ifdef ST_ARB_ROUND_ROBIN_EN
    logic [OW-1:0]    r_lastSel;
    logic [OW-1:0]    w_lastSelNext;
    logic [OW-1:0]    w_rrIdx;
    logic             w_found;

    // Search starts just past the previous owner so every master gets a turn.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_rrIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_rrIdx = OW'((int'(r_lastSel) + 1 + i) % NREQ);
            if (!w_found && req[w_rrIdx]) begin
                w_found = 1'b1;
                w_pick  = w_rrIdx;
            end
        end
    end
`else
    always_comb begin
        w_pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_pick = OW'(i);
            end
        end
    end
`endif

    assign w_unused      = phi1;
    assign w_holdExpired = (MAX_HOLD != 0) && (r_holdCnt == HOLD_LAST);

    // OWN is split by owner_valid: the first phi2 raises gnt, later ones watch for release.
    always_comb begin
        w_stateNext      = r_state;
        w_gntNext        = r_gnt;
        w_brNNext        = r_brN;
        w_bgackNNext     = r_bgackN;
        w_ownerValidNext = r_ownerValid;
        w_ownerNext      = r_owner;
        w_selNext        = r_sel;
        w_holdNext       = r_holdCnt;
`ifdef ST_ARB_ROUND_ROBIN_EN
        w_lastSelNext    = r_lastSel;
`endif
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_stateNext = REQ;
                    w_brNNext   = 1'b0;
                end
            end
            REQ: begin
                if (req == '0) begin
                    w_stateNext = IDLE;
                    w_brNNext   = 1'b1;
                end else if (!bg_n && as_n) begin
                    w_stateNext   = OWN;
                    w_brNNext     = 1'b1;
                    w_bgackNNext  = 1'b0;
                    w_selNext     = w_pick;
                    w_holdNext    = '0;
`ifdef ST_ARB_ROUND_ROBIN_EN
                    w_lastSelNext = w_pick;
`endif
                end
            end
            OWN: begin
                if (!r_ownerValid) begin
                    if (!req[r_sel]) begin
                        w_stateNext = REL;
                    end else begin
                        w_gntNext        = '0;
                        w_gntNext[r_sel] = 1'b1;
                        w_ownerValidNext = 1'b1;
                        w_ownerNext      = r_sel;
                    end
                end else begin
                    w_holdNext = r_holdCnt + CW'(1);
                    if (!req[r_sel] || w_holdExpired) begin
                        w_stateNext      = REL;
                        w_gntNext        = '0;
                        w_ownerValidNext = 1'b0;
                        w_ownerNext      = '0;
                    end
                end
            end
            REL: begin
                w_stateNext  = IDLE;
                w_bgackNNext = 1'b1;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_brN        <= 1'b1;
            r_bgackN     <= 1'b1;
            r_ownerValid <= 1'b0;
            r_owner      <= '0;
            r_sel        <= '0;
            r_holdCnt    <= '0;
`ifdef ST_ARB_ROUND_ROBIN_EN
            r_lastSel    <= OW'(NREQ - 1);
`endif
        end else if (phi2) begin
            r_state      <= w_stateNext;
            r_gnt        <= w_gntNext;
            r_brN        <= w_brNNext;
            r_bgackN     <= w_bgackNNext;
            r_ownerValid <= w_ownerValidNext;
            r_owner      <= w_ownerNext;
            r_sel        <= w_selNext;
            r_holdCnt    <= w_holdNext;
`ifdef ST_ARB_ROUND_ROBIN_EN
            r_lastSel    <= w_lastSelNext;
`endif
        end
    end

    assign gnt         = r_gnt;
    assign br_n        = r_brN;
    assign bgack_n     = r_bgackN;
    assign owner_valid = r_ownerValid;
    assign owner       = r_owner;

    // Handshake invariants: a single owner, owned only under bgack, never requesting while acknowledged.
    assert property (@(posedge clk) disable iff (reset) $onehot0(r_gnt));
    assert property (@(posedge clk) disable iff (reset) (r_gnt != '0) |-> !r_bgackN);
    assert property (@(posedge clk) disable iff (reset) !(!r_brN && !r_bgackN));

endmodule

// File: tb/tb_st_bus_arbiter.sv
// Directed bench for st_bus_arbiter: vector table for handshakes plus hand sequences for
// phi2 gating, reset mid-tenure, MAX_HOLD revoke and grant order (aware of ST_ARB_ROUND_ROBIN_EN).
module tb_st_bus_arbiter;

    localparam int NREQ = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            phi1;
    logic            phi2;
    logic [NREQ-1:0] req;
    logic            bg_n;
    logic            as_n;

    logic [NREQ-1:0] gnt;
    logic            brN;
    logic            bgackN;
    logic            ownerValid;
    logic            owner;

    logic [NREQ-1:0] holdGnt;
    logic            holdBrN;
    logic            holdBgackN;
    logic            holdOwnerValid;
    logic            holdOwner;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] req;
        logic       bgN;
        logic       asN;
        logic [1:0] gnt;
        logic       brN;
        logic       bgackN;
        logic       ov;
        logic       owner;
    } vecT;

    vecT vecs[$];

    st_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(0), .CW(8)) dut (
        .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .req(req),
        .gnt(gnt), .br_n(brN), .bg_n(bg_n), .bgack_n(bgackN), .as_n(as_n),
        .owner_valid(ownerValid), .owner(owner)
    );

    st_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(4), .CW(8)) dutHold (
        .clk(clk), .reset(reset), .phi1(phi1), .phi2(phi2), .req(req),
        .gnt(holdGnt), .br_n(holdBrN), .bg_n(bg_n), .bgack_n(holdBgackN), .as_n(as_n),
        .owner_valid(holdOwnerValid), .owner(holdOwner)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One phi2 pulse spanning a single rising edge, then an idle clk that must change nothing.
    task automatic stepPhi2();
        phi2 = 1'b1;
        @(negedge clk);
        phi2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic b, input logic a);
        req  = r;
        bg_n = b;
        as_n = a;
        stepPhi2();
    endtask

    task automatic checkMain(input string tag, input logic [1:0] eg, input logic eb,
                             input logic ea, input logic ev, input logic eo);
        checkOutput({tag, " gnt"}, int'(gnt), int'(eg));
        checkOutput({tag, " br_n"}, int'(brN), int'(eb));
        checkOutput({tag, " bgack_n"}, int'(bgackN), int'(ea));
        checkOutput({tag, " owner_valid"}, int'(ownerValid), int'(ev));
        checkOutput({tag, " owner"}, int'(owner), int'(eo));
    endtask

    task automatic checkHold(input string tag, input logic [1:0] eg, input logic eb,
                             input logic ea, input logic ev, input logic eo);
        checkOutput({tag, " hold gnt"}, int'(holdGnt), int'(eg));
        checkOutput({tag, " hold br_n"}, int'(holdBrN), int'(eb));
        checkOutput({tag, " hold bgack_n"}, int'(holdBgackN), int'(ea));
        checkOutput({tag, " hold owner_valid"}, int'(holdOwnerValid), int'(ev));
        checkOutput({tag, " hold owner"}, int'(holdOwner), int'(eo));
    endtask

    task automatic doReset();
        reset = 1'b1;
        req   = '0;
        bg_n  = 1'b1;
        as_n  = 1'b1;
        phi2  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic void addVec(input logic [1:0] r, input logic b, input logic a,
                                   input logic [1:0] g, input logic eb, input logic ea,
                                   input logic ev, input logic eo);
        vecT v;
        v.req = r; v.bgN = b; v.asN = a;
        v.gnt = g; v.brN = eb; v.bgackN = ea; v.ov = ev; v.owner = eo;
        vecs.push_back(v);
    endfunction

    initial begin
        int highCount;
        int revoked;
        int nGrants;
        int grants[3];
        int expSeq[3];
        logic [1:0] prevGnt;

        phi1 = 1'b0;
        doReset();
        checkMain("reset", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkHold("reset", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Without phi2 a pending request must not reach the CPU.
        req = 2'b01;
        repeat (3) @(negedge clk);
        checkMain("no phi2", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Single request handshake, release on req drop.
        addVec(2'b01, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b01, 0, 1, 2'b01, 1, 0, 1, 0);
        addVec(2'b01, 0, 1, 2'b01, 1, 0, 1, 0);
        addVec(2'b01, 0, 1, 2'b01, 1, 0, 1, 0);
        addVec(2'b01, 0, 1, 2'b01, 1, 0, 1, 0);
        addVec(2'b00, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b00, 1, 1, 2'b00, 1, 1, 0, 0);
        addVec(2'b00, 1, 1, 2'b00, 1, 1, 0, 0);
        // Priority, mandatory CPU phase between tenures, no preemption.
        addVec(2'b11, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b11, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b11, 0, 1, 2'b01, 1, 0, 1, 0);
        addVec(2'b10, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b10, 1, 1, 2'b00, 1, 1, 0, 0);
        addVec(2'b10, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b10, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b10, 0, 1, 2'b10, 1, 0, 1, 1);
        addVec(2'b11, 0, 1, 2'b10, 1, 0, 1, 1);
        addVec(2'b01, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b00, 1, 1, 2'b00, 1, 1, 0, 0);
        // Withdrawal wins over a simultaneous bus grant.
        addVec(2'b01, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b00, 0, 1, 2'b00, 1, 1, 0, 0);
        addVec(2'b00, 1, 1, 2'b00, 1, 1, 0, 0);
        // CPU cycle in flight delays the takeover.
        addVec(2'b01, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 1, 1, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 0, 0, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 0, 0, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 0, 0, 2'b00, 0, 1, 0, 0);
        addVec(2'b01, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b01, 0, 1, 2'b01, 1, 0, 1, 0);
        addVec(2'b00, 0, 1, 2'b00, 1, 0, 0, 0);
        addVec(2'b00, 1, 1, 2'b00, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].bgN, vecs[i].asN);
            checkMain($sformatf("vec%0d", i + 1), vecs[i].gnt, vecs[i].brN,
                      vecs[i].bgackN, vecs[i].ov, vecs[i].owner);
        end

        // Reset during a tenure with no phi2 present, then a fresh handshake.
        applyStimulus(2'b10, 1, 1);
        applyStimulus(2'b10, 0, 1);
        applyStimulus(2'b10, 0, 1);
        checkMain("pre reset own", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        bg_n  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkMain("reset in own", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 1, 1);
        checkMain("after reset req", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 0, 1);
        checkMain("after reset ack", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 0, 1);
        checkMain("after reset gnt", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);

        // MAX_HOLD=4 revoke with req held high.
        doReset();
        applyStimulus(2'b01, 1, 1);
        checkHold("to req", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 0, 1);
        checkHold("to own", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        highCount = 0;
        revoked   = 0;
        for (int s = 0; s < 20 && revoked == 0; s++) begin
            stepPhi2();
            if (holdGnt == 2'b01) highCount++;
            else revoked = 1;
        end
        checkOutput("timeout revoked", revoked, 1);
        checkOutput("timeout hold len", highCount, 4);
        checkHold("at revoke", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        stepPhi2();
        checkHold("revoke rel", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        stepPhi2();
        checkHold("revoke rereq", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        stepPhi2();
        checkHold("revoke reown", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Grant order under constant req=11 with revokes forcing re-arbitration.
`ifdef ST_ARB_ROUND_ROBIN_EN
        expSeq = '{1, 2, 1};
`else
        expSeq = '{1, 1, 1};
`endif
        doReset();
        req     = 2'b11;
        bg_n    = 1'b0;
        as_n    = 1'b1;
        prevGnt = 2'b00;
        nGrants = 0;
        grants  = '{0, 0, 0};
        for (int s = 0; s < 60 && nGrants < 3; s++) begin
            stepPhi2();
            if (holdGnt != 2'b00 && prevGnt == 2'b00) begin
                grants[nGrants] = int'(holdGnt);
                nGrants++;
            end
            prevGnt = holdGnt;
        end
        checkOutput("order grant count", nGrants, 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("order grant%0d", k), grants[k], expSeq[k]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
